// File: rtl/ibuf_pkg.sv
// rtl/ibuf_pkg.sv - shared types and constants for the instruction-buffer issue scheduler
package ibuf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FLUSH = 2'd2
   } sched_state_t;

   localparam int LAT_W         = 4;
   localparam int SHORT_LAT_DEF = 1;
   localparam int LONG_LAT_DEF  = 4;

   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ibuf_lat_counter.sv
// rtl/ibuf_lat_counter.sv - execute latency counter: load on issue, count down to zero
module ibuf_lat_counter
   import ibuf_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [LAT_W-1:0] load_val_i,
   output logic             busy_o,
   output logic             free_next_o
);

   logic [LAT_W-1:0] cnt_q, cnt_d;

   // A new issue reloads even when the previous instruction is in its last cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o      = (cnt_q != '0);
   assign free_next_o = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/ibuf_issue_scheduler.sv
// rtl/ibuf_issue_scheduler.sv - issue/bypass/push/stall decision between decode, L2 buffer and execute
module ibuf_issue_scheduler
   import ibuf_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int SHORT_LAT = SHORT_LAT_DEF,
   parameter int LONG_LAT  = LONG_LAT_DEF
)(
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        instr_in_valid_i,
   input  logic                        instr_is_long_i,
   output logic                        instr_in_stall_o,
   input  logic [count_w(DEPTH)-1:0]   buf_count_i,
   input  logic                        buf_head_is_long_i,
   output logic                        buf_push_o,
   output logic                        buf_pop_o,
   input  logic                        flush_i,
   output logic                        issue_valid_o,
   output logic                        issue_is_long_o,
   output logic                        issue_from_buf_o,
   output logic                        exec_busy_o,
   output logic                        exec_will_free_next_o
);

   localparam int              CW   = count_w(DEPTH);
   localparam logic [CW-1:0]   FULL = CW'(DEPTH);

   sched_state_t     state_q, state_d;
   logic             busy, free_next, can_issue, buf_empty, bypass;
   logic [LAT_W-1:0] lat_load;

   ibuf_lat_counter u_lat (
      .clk_i       (clk_i),
      .rst_i       (reset_i),
      .load_i      (issue_valid_o),
      .load_val_i  (lat_load),
      .busy_o      (busy),
      .free_next_o (free_next)
   );

   assign lat_load              = issue_is_long_o ? LAT_W'(LONG_LAT) : LAT_W'(SHORT_LAT);
   assign exec_busy_o           = busy & ~reset_i;
   assign exec_will_free_next_o = free_next & ~reset_i;

   // Buffer head always wins over decode so program order is preserved.
   always_comb begin
      buf_pop_o        = 1'b0;
      buf_push_o       = 1'b0;
      instr_in_stall_o = 1'b0;
      issue_valid_o    = 1'b0;
      issue_is_long_o  = 1'b0;
      issue_from_buf_o = 1'b0;
      bypass           = 1'b0;
      can_issue        = !busy || free_next;
      buf_empty        = (buf_count_i == '0);
      if (!reset_i) begin
         if (state_q == FLUSH) begin
            buf_pop_o        = !buf_empty;
            instr_in_stall_o = instr_in_valid_i;
         end else begin
            if (!buf_empty && can_issue) begin
               buf_pop_o        = 1'b1;
               issue_valid_o    = 1'b1;
               issue_from_buf_o = 1'b1;
               issue_is_long_o  = buf_head_is_long_i;
            end else if (buf_empty && instr_in_valid_i && can_issue) begin
               bypass          = 1'b1;
               issue_valid_o   = 1'b1;
               issue_is_long_o = instr_is_long_i;
            end
            if (instr_in_valid_i && !bypass) begin
               if (buf_count_i < FULL || buf_pop_o) begin
                  buf_push_o = 1'b1;
               end else begin
                  instr_in_stall_o = 1'b1;
               end
            end
         end
      end
   end

   // Counter is non-zero after the edge if we load it now or it has more than one cycle left.
   always_comb begin
      state_d = (issue_valid_o || (busy && !free_next)) ? BUSY : IDLE;
      if (flush_i) begin
         state_d = FLUSH;
      end else if (state_q == FLUSH && !buf_empty) begin
         state_d = FLUSH;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i)
      !(buf_pop_o && buf_empty));
   a_push_xor_stall: assert property (@(posedge clk_i) disable iff (reset_i)
      !(buf_push_o && instr_in_stall_o));
   a_issue_allowed: assert property (@(posedge clk_i) disable iff (reset_i)
      issue_valid_o |-> can_issue);

endmodule

// File: tb/tb_ibuf_issue_scheduler.sv
// tb/tb_ibuf_issue_scheduler.sv - randomized bench for ibuf_issue_scheduler against a cycle model
module tb_ibuf_issue_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, in_long = 1'b0, head_long = 1'b0, flush = 1'b0;
   logic [2:0] buf_count = '0;
   logic       stall, push, pop, iv, il, ifb, busy, fnext;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference state: buffered instruction classes, execute cycles left, flushing flag.
   bit q[$];
   int remaining = 0;
   bit flushing  = 1'b0;

   always #5 clk = ~clk;

   ibuf_issue_scheduler #(.DEPTH(4), .SHORT_LAT(1), .LONG_LAT(4)) dut (
      .clk_i                 (clk),
      .reset_i               (rst),
      .instr_in_valid_i      (in_valid),
      .instr_is_long_i       (in_long),
      .instr_in_stall_o      (stall),
      .buf_count_i           (buf_count),
      .buf_head_is_long_i    (head_long),
      .buf_push_o            (push),
      .buf_pop_o             (pop),
      .flush_i               (flush),
      .issue_valid_o         (iv),
      .issue_is_long_o       (il),
      .issue_from_buf_o      (ifb),
      .exec_busy_o           (busy),
      .exec_will_free_next_o (fnext)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
   endtask

   task automatic step(input bit v, input bit lg, input bit fl, input bit r, output bit stalled);
      bit e_stall, e_push, e_pop, e_iv, e_il, e_ifb, bypass, can;
      int sz;
      e_stall = 0; e_push = 0; e_pop = 0; e_iv = 0; e_il = 0; e_ifb = 0; bypass = 0;
      @(negedge clk);
      cyc++;
      if (r) begin
         q.delete();
         remaining = 0;
         flushing  = 1'b0;
      end
      rst = r; in_valid = v; in_long = lg; flush = fl;
      sz = q.size();
      buf_count = 3'(sz);
      head_long = (sz != 0) ? q[0] : 1'($urandom_range(1));
      can = (remaining <= 1);
      if (!r) begin
         if (flushing) begin
            e_pop   = (sz != 0);
            e_stall = v;
         end else begin
            if (sz != 0 && can) begin
               e_pop = 1; e_iv = 1; e_ifb = 1; e_il = q[0];
            end else if (sz == 0 && v && can) begin
               bypass = 1; e_iv = 1; e_il = lg;
            end
            if (v && !bypass) begin
               if (sz < 4 || e_pop) e_push = 1;
               else e_stall = 1;
            end
         end
      end
      #1;
      check("instr_in_stall", stall, e_stall);
      check("buf_push", push, e_push);
      check("buf_pop", pop, e_pop);
      check("issue_valid", iv, e_iv);
      check("issue_is_long", il, e_il);
      check("issue_from_buf", ifb, e_ifb);
      check("exec_busy", busy, (!r && remaining > 0));
      check("exec_will_free_next", fnext, (!r && remaining == 1));
      stalled = e_stall;
      @(posedge clk);
      if (!r) begin
         if (e_pop) void'(q.pop_front());
         if (e_push) q.push_back(lg);
         if (e_iv) remaining = e_il ? 4 : 1;
         else if (remaining > 0) remaining--;
         if (fl) flushing = 1'b1;
         else if (flushing && sz == 0) flushing = 1'b0;
      end
   endtask

   initial begin
      bit s, pv, pl;
      step(0, 0, 0, 1, s);
      step(0, 0, 0, 1, s);
      // back-to-back short bypasses
      step(1, 0, 0, 0, s);
      step(1, 0, 0, 0, s);
      step(0, 0, 0, 0, s);
      // long bypass then three shorts queue behind it
      step(1, 1, 0, 0, s);
      repeat (3) step(1, 0, 0, 0, s);
      repeat (5) step(0, 0, 0, 0, s);
      // stream of longs fills the buffer; stalled decode holds its instruction
      repeat (8) step(1, 1, 0, 0, s);
      repeat (24) step(0, 0, 0, 0, s);
      // ordering: buffer non-empty with execute free, decode valid
      step(1, 1, 0, 0, s);
      step(1, 0, 0, 0, s);
      step(1, 0, 0, 0, s);
      repeat (3) step(1, 0, 0, 0, s);
      repeat (8) step(0, 0, 0, 0, s);
      // flush with a long in flight and a partly full buffer
      step(1, 1, 0, 0, s);
      step(1, 0, 0, 0, s);
      step(1, 0, 0, 0, s);
      step(1, 1, 1, 0, s);
      repeat (6) step(1, 0, 0, 0, s);
      repeat (6) step(0, 0, 0, 0, s);
      // reset while the execute unit is busy
      step(1, 1, 0, 0, s);
      step(1, 0, 0, 0, s);
      step(0, 0, 0, 1, s);
      repeat (3) step(0, 0, 0, 0, s);
      // random traffic; a stalled decode re-presents the same instruction
      s = 0; pv = 0; pl = 0;
      for (int i = 0; i < 3000; i++) begin
         bit fl, r;
         if (!s) begin
            pv = ($urandom_range(9) < 7);
            pl = ($urandom_range(9) < 4);
         end
         fl = ($urandom_range(31) == 0);
         r  = ($urandom_range(127) == 0);
         step(pv, pl, fl, r, s);
         if (r) s = 0;
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
